ctrl_pipe: RTL and testbench

Carries decoded control signals from the ID stage through the EX, MEM and WB pipeline registers of the 5-stage pipeline, and resolves hazards on the way. It sits directly after the opcode decoder, consuming its alu_op/beq/mem_read/mem_write/alu_src/mem_to_reg/reg_write outputs. It drives every downstream stage's control, generates load-use stalls and produces forwarding selects. It also flushes wrong-path instructions when a BEQ resolves taken in MEM.

---
 rtl/ctrl_pipe.sv | 153 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall detection,
// operand forwarding selects and branch flush for a 5-stage in-order core.
module ctrl_pipe #(
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [1:0]    id_alu_op,
  input  logic          id_beq,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_alu_src,
  input  logic          id_mem_to_reg,
  input  logic          id_reg_write,
  input  logic [RA-1:0] id_rs1,
  input  logic [RA-1:0] id_rs2,
  input  logic [RA-1:0] id_rd,
  input  logic          id_uses_rs2,
  input  logic          mem_zero,
  output logic          stall,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          if_id_flush,
  output logic [1:0]    ex_alu_op,
  output logic          ex_alu_src,
  output logic [RA-1:0] ex_rs1,
  output logic [RA-1:0] ex_rs2,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic          mem_beq,
  output logic          branch_taken,
  output logic          wb_reg_write,
  output logic          wb_mem_to_reg,
  output logic [RA-1:0] wb_rd
);

  typedef struct packed {
    logic [1:0]    alu_op;
    logic          alu_src;
    logic          beq;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          reg_write;
    logic [RA-1:0] rd;
    logic [RA-1:0] rs1;
    logic [RA-1:0] rs2;
    logic          valid;
  } idex_t;

  typedef struct packed {
    logic          beq;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          reg_write;
    logic [RA-1:0] rd;
    logic          valid;
  } exmem_t;

  typedef struct packed {
    logic          mem_to_reg;
    logic          reg_write;
    logic [RA-1:0] rd;
    logic          valid;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   ld_hazard;

  // Newest producer wins: EX/MEM is checked before MEM/WB; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RA-1:0] rs,
                                         input exmem_t m, input memwb_t w);
    if (rs == '0)                                 return 2'b00;
    if (m.valid && m.reg_write && (m.rd == rs))   return 2'b10;
    if (w.valid && w.reg_write && (w.rd == rs))   return 2'b01;
    return 2'b00;
  endfunction

  assign branch_taken = exmem_q.beq & mem_zero;
  assign ld_hazard    = id_valid & idex_q.valid & idex_q.mem_read & (idex_q.rd != '0) &
                        ((idex_q.rd == id_rs1) | (id_uses_rs2 & (idex_q.rd == id_rs2)));
  // A taken branch kills the dependent instruction anyway, so the flush suppresses the stall.
  assign stall        = ld_hazard & ~branch_taken;
  assign pc_write     = ~stall;
  assign ifid_write   = ~stall;
  assign if_id_flush  = branch_taken;

  assign fwd_a = fwd_sel(idex_q.rs1, exmem_q, memwb_q);
  assign fwd_b = fwd_sel(idex_q.rs2, exmem_q, memwb_q);

  always_comb begin
    idex_d = '0;
    if (id_valid && !stall && !branch_taken) begin
      idex_d.alu_op     = id_alu_op;
      idex_d.alu_src    = id_alu_src;
      idex_d.beq        = id_beq;
      idex_d.mem_read   = id_mem_read;
      idex_d.mem_write  = id_mem_write;
      idex_d.mem_to_reg = id_mem_to_reg;
      idex_d.reg_write  = id_reg_write;
      idex_d.rd         = id_rd;
      idex_d.rs1        = id_rs1;
      idex_d.rs2        = id_rs2;
      idex_d.valid      = 1'b1;
    end

    exmem_d = '0;
    if (!branch_taken) begin
      exmem_d.beq        = idex_q.beq;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.rd         = idex_q.rd;
      exmem_d.valid      = idex_q.valid;
    end

    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.rd         = exmem_q.rd;
    memwb_d.valid      = exmem_q.valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_alu_op     = idex_q.alu_op;
  assign ex_alu_src    = idex_q.alu_src;
  assign ex_rs1        = idex_q.rs1;
  assign ex_rs2        = idex_q.rs2;
  assign mem_mem_read  = exmem_q.mem_read;
  assign mem_mem_write = exmem_q.mem_write;
  assign mem_beq       = exmem_q.beq;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_rd         = memwb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed hazard scenarios plus random instruction streams,
// compared against an instruction-level model of the three pipeline slots.
module tb_ctrl_pipe;
  localparam int RA = 3;

  typedef struct packed {
    logic [1:0] op;
    logic       src, beq, mr, mw, m2r, rw, u2;
    logic [2:0] rs1, rs2, rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic mem_zero = 1'b0;
  ins_t cur = '0;

  logic          stall, pc_write, ifid_write, if_id_flush, ex_alu_src;
  logic [1:0]    ex_alu_op, fwd_a, fwd_b;
  logic [RA-1:0] ex_rs1, ex_rs2, wb_rd;
  logic          mem_mem_read, mem_mem_write, mem_beq, branch_taken;
  logic          wb_reg_write, wb_mem_to_reg;

  always #5 clk = ~clk;

  ctrl_pipe #(.RA(RA)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_alu_op(cur.op), .id_beq(cur.beq), .id_mem_read(cur.mr), .id_mem_write(cur.mw),
    .id_alu_src(cur.src), .id_mem_to_reg(cur.m2r), .id_reg_write(cur.rw),
    .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_rd(cur.rd), .id_uses_rs2(cur.u2),
    .mem_zero(mem_zero),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write), .if_id_flush(if_id_flush),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_beq(mem_beq),
    .branch_taken(branch_taken),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  ins_t m_ex = '0, m_mem = '0, m_wb = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 R-type, 1 LW, 2 SW, 3 BEQ
  function automatic ins_t mk(input int kind, input int op, input int rs1, input int rs2, input int rd);
    ins_t r;
    r = '0;
    r.rs1 = 3'(rs1);
    r.rs2 = 3'(rs2);
    r.rd  = 3'(rd);
    case (kind)
      0: begin r.op = 2'(op); r.rw = 1'b1; r.u2 = 1'b1; end
      1: begin r.src = 1'b1; r.mr = 1'b1; r.m2r = 1'b1; r.rw = 1'b1; end
      2: begin r.src = 1'b1; r.mw = 1'b1; r.u2 = 1'b1; end
      default: begin r.op = 2'b01; r.beq = 1'b1; r.u2 = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic logic exp_taken();
    return m_mem.beq && mem_zero;
  endfunction

  function automatic logic exp_stall();
    logic dep;
    dep = (m_ex.rd == cur.rs1) || (cur.u2 && (m_ex.rd == cur.rs2));
    return id_valid && m_ex.mr && (m_ex.rd != 3'd0) && dep && !exp_taken();
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [2:0] rs);
    if (rs == 3'd0) return 2'b00;
    if (m_mem.rw && m_mem.rd == rs) return 2'b10;
    if (m_wb.rw && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_all();
    logic tk, st;
    tk = exp_taken();
    st = exp_stall();
    chk("stall", 16'(stall), 16'(st));
    chk("pc_write", 16'(pc_write), 16'(!st));
    chk("ifid_write", 16'(ifid_write), 16'(!st));
    chk("branch_taken", 16'(branch_taken), 16'(tk));
    chk("if_id_flush", 16'(if_id_flush), 16'(tk));
    chk("ex_bundle", 16'({ex_alu_op, ex_alu_src, ex_rs1, ex_rs2}),
        16'({m_ex.op, m_ex.src, m_ex.rs1, m_ex.rs2}));
    chk("fwd_a", 16'(fwd_a), 16'(exp_fwd(m_ex.rs1)));
    chk("fwd_b", 16'(fwd_b), 16'(exp_fwd(m_ex.rs2)));
    chk("mem_bundle", 16'({mem_mem_read, mem_mem_write, mem_beq}), 16'({m_mem.mr, m_mem.mw, m_mem.beq}));
    chk("wb_bundle", 16'({wb_reg_write, wb_mem_to_reg, wb_rd}), 16'({m_wb.rw, m_wb.m2r, m_wb.rd}));
  endtask

  // Check settled outputs, take one clock edge, advance the model the same way.
  task automatic tick();
    logic tk, st;
    #1;
    check_all();
    tk = exp_taken();
    st = exp_stall();
    @(posedge clk);
    if (!rst_n) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else begin
      m_wb  = m_mem;
      m_mem = tk ? '0 : m_ex;
      m_ex  = (id_valid && !st && !tk) ? cur : '0;
    end
    #1;
  endtask

  task automatic put(input ins_t i);
    cur = i;
    id_valid = 1'b1;
  endtask

  task automatic nop();
    cur = '0;
    id_valid = 1'b0;
  endtask

  function automatic ins_t rnd_ins();
    return mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      cur = rnd_ins();
      id_valid = 1'($urandom);
      mem_zero = 1'($urandom);
      tick();
    end
    chk("rst_pc_write", 16'(pc_write), 16'd1);
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_fwd", 16'({fwd_a, fwd_b}), 16'd0);
    rst_n = 1'b1;
    mem_zero = 1'b0;
    nop();
    tick();

    // ADD r1 ; SUB r2,r1,r3 ; AND r6,r1,r7
    put(mk(0, 0, 2, 3, 1)); tick();
    put(mk(0, 1, 1, 3, 2)); tick();
    put(mk(0, 2, 1, 7, 6)); #1 chk("fwd_a_from_mem", 16'(fwd_a), 16'd2); tick();
    nop(); #1 chk("fwd_a_from_wb", 16'(fwd_a), 16'd1); tick();
    tick(); tick();

    // LW r4 ; ADD r5,r4,r4 (load-use)
    put(mk(1, 0, 1, 0, 4)); tick();
    put(mk(0, 0, 4, 4, 5));
    #1 chk("lu_stall", 16'(stall), 16'd1);
    chk("lu_pc_write", 16'(pc_write), 16'd0);
    tick();
    #1 chk("lu_stall_released", 16'(stall), 16'd0);
    chk("lu_ex_bubble", 16'({ex_alu_op, ex_alu_src, ex_rs1, ex_rs2}), 16'd0);
    tick();
    nop();
    #1 chk("lu_fwd_ab", 16'({fwd_a, fwd_b}), 16'b0101);
    tick(); tick(); tick();

    // BEQ taken with SW behind it
    put(mk(3, 0, 1, 2, 0)); tick();
    put(mk(2, 0, 3, 4, 0)); tick();
    mem_zero = 1'b1;
    put(mk(0, 0, 1, 1, 5));
    #1 chk("beq_taken", 16'({branch_taken, if_id_flush}), 16'b11);
    tick();
    mem_zero = 1'b0;
    nop();
    #1 chk("flush_ex", 16'({ex_alu_op, ex_alu_src, ex_rs1, ex_rs2}), 16'd0);
    chk("flush_mem_write", 16'(mem_mem_write), 16'd0);
    tick(); tick();

    // Taken BEQ coincident with a load-use hazard: flush wins
    put(mk(3, 0, 1, 2, 0)); tick();
    put(mk(1, 0, 1, 0, 4)); tick();
    mem_zero = 1'b1;
    put(mk(0, 0, 4, 4, 5));
    #1 chk("flush_over_stall", 16'({branch_taken, stall}), 16'b10);
    tick();
    mem_zero = 1'b0;
    nop(); tick(); tick();

    // BEQ not taken: SW proceeds
    put(mk(3, 0, 1, 2, 0)); tick();
    put(mk(2, 0, 3, 4, 0)); tick();
    put(mk(0, 0, 1, 1, 5));
    #1 chk("beq_not_taken", 16'(branch_taken), 16'd0);
    tick();
    nop();
    #1 chk("sw_reaches_mem", 16'(mem_mem_write), 16'd1);
    tick(); tick(); tick();

    // Back-to-back BEQs: second is flushed
    put(mk(3, 0, 1, 2, 0)); tick();
    put(mk(3, 0, 3, 3, 0)); tick();
    nop(); mem_zero = 1'b1; tick();
    mem_zero = 1'b0;
    #1 chk("second_beq_flushed", 16'(mem_beq), 16'd0);
    tick(); tick();

    // r0 is never forwarded nor stalled on
    put(mk(0, 0, 1, 2, 0)); tick();
    put(mk(0, 2, 0, 3, 6)); tick();
    nop(); #1 chk("r0_no_fwd", 16'(fwd_a), 16'd0); tick(); tick(); tick();
    put(mk(1, 0, 1, 0, 0)); tick();
    put(mk(0, 0, 0, 0, 5)); #1 chk("r0_no_stall", 16'(stall), 16'd0); tick();
    nop(); tick(); tick(); tick();

    // Random streams with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      cur = rnd_ins();
      id_valid = ($urandom_range(0, 7) != 0);
      mem_zero = 1'($urandom);
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        m_ex = '0; m_mem = '0; m_wb = '0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
